microwave_time_entry: RTL



---
 rtl/microwave_time_entry_if.sv | 28 ++
 rtl/microwave_time_entry.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/microwave_time_entry_if.sv
// Keypad/timer-side signal bundle for microwave_time_entry.
// master = keypad and timer environment, slave = the entry block.
interface microwave_time_entry_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       cancel;
  logic       zero;
  logic [3:0] uni_sec;
  logic [3:0] dez_sec;
  logic [3:0] min;
  logic       load;
  logic       enable;
  logic       cnt_clear;
  logic       key_err;
  logic       done;
  logic       busy;

  modport master (
    output key_valid, key_code, start, cancel, zero,
    input  uni_sec, dez_sec, min, load, enable, cnt_clear, key_err, done, busy
  );

  modport slave (
    input  key_valid, key_code, start, cancel, zero,
    output uni_sec, dez_sec, min, load, enable, cnt_clear, key_err, done, busy
  );
endinterface

// File: rtl/microwave_time_entry.sv
// Keypad time entry and run control for the microwave countdown timer.
// Optional macro QUICK_START_EN: start with 0:00 loads a 30-second quick start.
module microwave_time_entry #(
  parameter int DONE_CYCLES = 4,
  parameter int MAX_DEZ     = 5
) (
  input  logic                   clk,
  input  logic                   clear_n,
  microwave_time_entry_if.slave  bus
);
  localparam int CW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DONE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, PAUSED, DONE} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    uni_reg, uni_next;
  logic [3:0]    dez_reg, dez_next;
  logic [3:0]    min_reg, min_next;
  logic          armed_reg, armed_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          load_reg, load_next;
  logic          enable_reg, enable_next;
  logic          cnt_clear_reg, cnt_clear_next;
  logic          key_err_reg, key_err_next;
  logic          done_reg, done_next;
  logic          busy_reg, busy_next;
  logic          digits_zero;

  assign digits_zero = (uni_reg == 4'd0) && (dez_reg == 4'd0) && (min_reg == 4'd0);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_reg     <= IDLE;
      uni_reg       <= '0;
      dez_reg       <= '0;
      min_reg       <= '0;
      armed_reg     <= 1'b0;
      cnt_reg       <= '0;
      load_reg      <= 1'b0;
      enable_reg    <= 1'b0;
      cnt_clear_reg <= 1'b0;
      key_err_reg   <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      uni_reg       <= uni_next;
      dez_reg       <= dez_next;
      min_reg       <= min_next;
      armed_reg     <= armed_next;
      cnt_reg       <= cnt_next;
      load_reg      <= load_next;
      enable_reg    <= enable_next;
      cnt_clear_reg <= cnt_clear_next;
      key_err_reg   <= key_err_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    uni_next       = uni_reg;
    dez_next       = dez_reg;
    min_next       = min_reg;
    armed_next     = armed_reg;
    cnt_next       = cnt_reg;
    cnt_clear_next = 1'b0;
    key_err_next   = 1'b0;

    case (state_reg)
      IDLE, ENTRY: begin
        if (bus.cancel) begin
          state_next     = IDLE;
          uni_next       = '0;
          dez_next       = '0;
          min_next       = '0;
          cnt_clear_next = 1'b1;
        end else if (bus.start) begin
          if (digits_zero) begin
`ifdef QUICK_START_EN
            min_next   = 4'd0;
            dez_next   = 4'd3;
            uni_next   = 4'd0;
            state_next = LOAD;
`endif
          end else begin
            state_next = LOAD;
          end
        end else if (bus.key_valid) begin
          // The current units digit becomes tens-of-seconds, so it must fit mod-6.
          if (bus.key_code > 4'd9 || uni_reg > 4'(MAX_DEZ)) begin
            key_err_next = 1'b1;
          end else begin
            min_next   = dez_reg;
            dez_next   = uni_reg;
            uni_next   = bus.key_code;
            state_next = ENTRY;
          end
        end
      end
      LOAD: begin
        state_next = RUN;
        armed_next = 1'b0;
      end
      RUN: begin
        if (bus.cancel) begin
          state_next = PAUSED;
        end else if (!armed_reg) begin
          // Timer may still show the stale 0:00 while loading; skip one zero sample.
          armed_next = 1'b1;
        end else if (bus.zero) begin
          state_next = DONE;
          cnt_next   = '0;
        end
      end
      PAUSED: begin
        if (bus.cancel) begin
          state_next     = IDLE;
          uni_next       = '0;
          dez_next       = '0;
          min_next       = '0;
          cnt_clear_next = 1'b1;
        end else if (bus.start) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (bus.cancel || cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          uni_next   = '0;
          dez_next   = '0;
          min_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    load_next   = (state_next == LOAD);
    enable_next = (state_next == RUN);
    done_next   = (state_next == DONE);
    busy_next   = (state_next == LOAD) || (state_next == RUN) ||
                  (state_next == PAUSED) || (state_next == DONE);
  end

  assign bus.uni_sec   = uni_reg;
  assign bus.dez_sec   = dez_reg;
  assign bus.min       = min_reg;
  assign bus.load      = load_reg;
  assign bus.enable    = enable_reg;
  assign bus.cnt_clear = cnt_clear_reg;
  assign bus.key_err   = key_err_reg;
  assign bus.done      = done_reg;
  assign bus.busy      = busy_reg;
endmodule
